// File: rtl/db_pkg.sv
`default_nettype none
// ============================================================================
// Module      : db_pkg
// Description : Shared state encoding and default timing constants for the
//               two-channel button debounce / one-pulse conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package db_pkg;

    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_CHANGING = 1'b1;

    // 1 ms debounce and 1 s long-press at 100 MHz
    localparam int DEB_CYCLES_DEF  = 100000;
    localparam int LONG_CYCLES_DEF = 100000000;

endpackage : db_pkg
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : debounce_ch
// Description : Single button channel: two-flop synchroniser, debounce FSM,
//               press pulse and (with LONG_PRESS_EN) long-press pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_ch
    import db_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int CNT_W       = $clog2(DEB_CYCLES + 1),
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse,
`ifdef LONG_PRESS_EN
    output logic o_long,
`endif
    output logic o_level
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;
    logic             r_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= ST_STABLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_pulse   <= r_level & ~r_level_d;

            case (r_state)
                ST_STABLE: begin
                    if (r_sync2 != r_level) begin
                        r_state <= ST_CHANGING;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                ST_CHANGING: begin
                    // Any sample agreeing with the current level is a bounce
                    if (r_sync2 == r_level) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_level <= ~r_level;
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_pulse = r_pulse;
    assign o_level = r_level;

`ifdef LONG_PRESS_EN
    localparam int              c_long_w    = $clog2(LONG_CYCLES + 1);
    localparam logic [c_long_w-1:0] c_hold_max  = c_long_w'(LONG_CYCLES);
    localparam logic [c_long_w-1:0] c_hold_last = c_long_w'(LONG_CYCLES - 1);

    logic [c_long_w-1:0] r_hold;
    logic                r_long;

    // Saturating past the trigger value keeps the pulse to one per press
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            if (!r_level) begin
                r_hold <= '0;
            end else if (r_hold != c_hold_max) begin
                r_hold <= r_hold + c_long_w'(1);
            end
            r_long <= r_level && (r_hold == c_hold_last);
        end
    end

    assign o_long = r_long;
`else
    logic w_unused_long_cycles;
    assign w_unused_long_cycles = (LONG_CYCLES > 0);
`endif

endmodule : debounce_ch
`default_nettype wire

// File: rtl/debounce_onepulse.sv
`default_nettype none
// ============================================================================
// Module      : debounce_onepulse
// Description : Two independent button conditioners producing debounced
//               levels and one-cycle press pulses. Define LONG_PRESS_EN to
//               add long-press pulse outputs long0/long1.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_onepulse
    import db_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int CNT_W       = $clog2(DEB_CYCLES + 1),
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn0,
    input  logic btn1,
    output logic out0,
    output logic out1,
`ifdef LONG_PRESS_EN
    output logic long0,
    output logic long1,
`endif
    output logic level0,
    output logic level1
);

    debounce_ch #(
        .DEB_CYCLES  (DEB_CYCLES),
        .CNT_W       (CNT_W),
        .LONG_CYCLES (LONG_CYCLES)
    ) u_ch0 (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn0),
        .o_pulse (out0),
`ifdef LONG_PRESS_EN
        .o_long  (long0),
`endif
        .o_level (level0)
    );

    debounce_ch #(
        .DEB_CYCLES  (DEB_CYCLES),
        .CNT_W       (CNT_W),
        .LONG_CYCLES (LONG_CYCLES)
    ) u_ch1 (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn1),
        .o_pulse (out1),
`ifdef LONG_PRESS_EN
        .o_long  (long1),
`endif
        .o_level (level1)
    );

endmodule : debounce_onepulse
`default_nettype wire

// File: tb/tb_debounce_onepulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_onepulse
// Description : Directed bench for debounce_onepulse (DEB_CYCLES=4,
//               LONG_CYCLES=20); pulse times are queued when stimulus is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_onepulse;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn0 = 1'b0;
    logic btn1 = 1'b0;
    logic out0, out1, level0, level1;
`ifdef LONG_PRESS_EN
    logic long0, long1;
`endif

    int edge_n = 0;
    int tests  = 0;
    int fails  = 0;
    int q0[$];
    int q1[$];
`ifdef LONG_PRESS_EN
    int ql0[$];
    int ql1[$];
`endif

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    debounce_onepulse #(
        .DEB_CYCLES  (4),
        .LONG_CYCLES (20)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn0   (btn0),
        .btn1   (btn1),
        .out0   (out0),
        .out1   (out1),
`ifdef LONG_PRESS_EN
        .long0  (long0),
        .long1  (long1),
`endif
        .level0 (level0),
        .level1 (level1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // Returns at the falling edge following active edge n
    task automatic wait_edge(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    // Scoreboard: each observed pulse must match the oldest queued edge
    always @(negedge clk) begin
        if (out0 === 1'b1) begin
            check("out0_expected", 32'(q0.size() > 0), 1);
            if (q0.size() > 0) check("out0_edge", edge_n, q0.pop_front());
        end
        if (out1 === 1'b1) begin
            check("out1_expected", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) check("out1_edge", edge_n, q1.pop_front());
        end
`ifdef LONG_PRESS_EN
        if (long0 === 1'b1) begin
            check("long0_expected", 32'(ql0.size() > 0), 1);
            if (ql0.size() > 0) check("long0_edge", edge_n, ql0.pop_front());
        end
        if (long1 === 1'b1) begin
            check("long1_expected", 32'(ql1.size() > 0), 1);
            if (ql1.size() > 0) check("long1_edge", edge_n, ql1.pop_front());
        end
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:8] pat;
        pat = 9'b101101111;

        // Reset state
        wait_edge(3);
        check("rst_out0", out0, 0);
        check("rst_out1", out1, 0);
        check("rst_level0", level0, 0);
        check("rst_level1", level1, 0);
        rst = 1'b0;

        // Clean press sampled at edge 10
        wait_edge(9);
        btn0 = 1'b1;
        q0.push_back(16);
`ifdef LONG_PRESS_EN
        ql0.push_back(35);
`endif
        wait_edge(14);
        check("clean_level0_pre", level0, 0);
        wait_edge(15);
        check("clean_level0_rise", level0, 1);
        wait_edge(20);
        check("clean_q0_drained", q0.size(), 0);
        wait_edge(39);
        btn0 = 1'b0;
        wait_edge(44);
        check("clean_level0_hold", level0, 1);
        wait_edge(45);
        check("clean_level0_fall", level0, 0);

        // Bounce: last low sampled at edge 64, stable high from edge 65
        q0.push_back(71);
        for (int i = 0; i < 9; i++) begin
            wait_edge(59 + i);
            btn0 = pat[i];
        end
        wait_edge(69);
        check("bounce_level0_pre", level0, 0);
        wait_edge(70);
        check("bounce_level0_rise", level0, 1);
        wait_edge(79);
        check("bounce_q0_drained", q0.size(), 0);
        btn0 = 1'b0;
        wait_edge(90);
        check("bounce_level0_fall", level0, 0);

        // Short glitch on channel 1: three high samples only
        wait_edge(99);
        btn1 = 1'b1;
        for (int e = 100; e <= 110; e++) begin
            wait_edge(e);
            check("glitch_level1", level1, 0);
            if (e == 102) btn1 = 1'b0;
        end

        // Simultaneous press on both channels
        wait_edge(119);
        btn0 = 1'b1;
        btn1 = 1'b1;
        q0.push_back(126);
        q1.push_back(126);
        wait_edge(125);
        check("sim_level0", level0, 1);
        check("sim_level1", level1, 1);
        wait_edge(126);
        check("sim_out0", out0, 1);
        check("sim_out1", out1, 1);
        wait_edge(134);
        btn0 = 1'b0;
        btn1 = 1'b0;
        wait_edge(145);
        check("sim_level0_fall", level0, 0);
        check("sim_level1_fall", level1, 0);
        check("sim_q0_drained", q0.size(), 0);
        check("sim_q1_drained", q1.size(), 0);

        // Reset two cycles after level0 rises, button held throughout
        wait_edge(159);
        btn0 = 1'b1;
        q0.push_back(166);
        wait_edge(165);
        check("rstmid_level0_rise", level0, 1);
        wait_edge(166);
        rst = 1'b1;
        wait_edge(167);
        check("rstmid_level0_a", level0, 0);
        check("rstmid_out0_a", out0, 0);
        wait_edge(168);
        check("rstmid_level0_b", level0, 0);
        check("rstmid_out0_b", out0, 0);
        check("rstmid_out1_b", out1, 0);
        rst = 1'b0;
        q0.push_back(175);
        wait_edge(169);
        check("rstmid_level0_after", level0, 0);
        check("rstmid_out0_after", out0, 0);
        wait_edge(173);
        check("rstmid_level0_pre", level0, 0);
        wait_edge(174);
        check("rstmid_level0_rise2", level0, 1);
        wait_edge(180);
        check("rstmid_q0_drained", q0.size(), 0);
        btn0 = 1'b0;

        // Long hold: 40 cycles
        wait_edge(199);
        btn0 = 1'b1;
        q0.push_back(206);
`ifdef LONG_PRESS_EN
        ql0.push_back(225);
`endif
        wait_edge(205);
        check("long_level0_rise", level0, 1);
        wait_edge(239);
        btn0 = 1'b0;
        wait_edge(260);
        check("long_level0_fall", level0, 0);
        check("final_q0_drained", q0.size(), 0);
        check("final_q1_drained", q1.size(), 0);
`ifdef LONG_PRESS_EN
        check("final_ql0_drained", ql0.size(), 0);
        check("final_ql1_drained", ql1.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_debounce_onepulse
`default_nettype wire

// File: doc/debounce_onepulse.md
Name: debounce_onepulse

Overview:
- Two-channel button conditioner that sits directly upstream of the start/stop toggle FSM.
- Each raw push-button input is synchronised, debounced, and converted to a single-cycle pulse on press. These pulses drive the FSM's out0/out1 inputs.
- Guarantees one toggle per physical press, regardless of bounce or hold time.

Parameters:
- DEB_CYCLES, 100000: consecutive stable synchronised samples required to accept a level change (1 ms at 100 MHz). Must be >= 2.
- CNT_W, $clog2(DEB_CYCLES+1): debounce counter width (derived; do not override).
- LONG_CYCLES, 100000000: cycles of debounced-high before a long-press pulse. Used only with LONG_PRESS_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- btn0  in  1  raw asynchronous button, channel 0, active-high
- btn1  in  1  raw asynchronous button, channel 1, active-high
- out0  out  1  one-cycle press pulse, channel 0 (feeds FSM out0)
- out1  out  1  one-cycle press pulse, channel 1 (feeds FSM out1)
- level0  out  1  debounced level, channel 0
- level1  out  1  debounced level, channel 1
- long0  out  1  long-press pulse, channel 0 (only with LONG_PRESS_EN)
- long1  out  1  long-press pulse, channel 1 (only with LONG_PRESS_EN)

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Channels are fully independent and identical. Description below is per channel.
- Synchroniser: two flops, sync1 <= btn, sync2 <= sync1. Reset value 0.
- Debounced level register `level` resets to 0. Counter `cnt` resets to 0.
- State machine:
  - STABLE: sync2 == level; cnt held at 0. On sync2 != level, go to CHANGING with cnt <= 1.
  - CHANGING: if sync2 == level (glitch), go to STABLE with cnt <= 0.
  - CHANGING: else if cnt == DEB_CYCLES-1, then level <= ~level, cnt <= 0, go to STABLE.
  - CHANGING: else cnt <= cnt+1.
- Press pulse: out is registered. out <= 1 in the cycle after the edge where level goes 0->1, for exactly one cycle; otherwise 0. A release (1->0) generates no pulse.
- Latency: for a clean raw rise sampled at edge k, level rises at edge k+1+DEB_CYCLES and out is high for the cycle starting at edge k+2+DEB_CYCLES.
- Bounce: any sample of sync2 equal to level during CHANGING restarts the count. The accepted change needs DEB_CYCLES consecutive differing samples.
- Hold: no further pulses while held, for any hold duration.
- Both channels may pulse in the same cycle; there is no arbitration.
- Reset mid-operation: all flops clear on the next edge with rst=1, and any in-flight pulse is dropped. A button held through reset is seen as a new press after rst falls, giving a pulse DEB_CYCLES+3 cycles later.
- All outputs are 0 during reset and the cycle after.

Optional Feature:
- Macro: LONG_PRESS_EN.
- With the macro, each channel adds a hold counter.
  - The counter clears when level=0 and increments (saturating) while level=1.
  - When it reaches LONG_CYCLES-1, long<=1 for exactly one cycle, once per press.
  - It resets to 0 on rst.
- Without the macro, long0/long1 ports and the hold counter are absent. out/level behaviour is unchanged.

Decomposition:
- Shared package db_pkg holds:
  - the state encoding localparams (ST_STABLE=1'b0, ST_CHANGING=1'b1);
  - default constants DEB_CYCLES_DEF and LONG_CYCLES_DEF.
- One sub-module, debounce_ch: single-channel synchroniser, debounce FSM, pulse and optional long-press logic.
- debounce_onepulse instantiates debounce_ch twice and passes parameters through.

Test Plan (bench overrides DEB_CYCLES=4, LONG_CYCLES=20):
- Clean press: btn0 0->1 sampled at edge 10, held 30 cycles. Required: level0 rises at edge 15; out0 high only in the cycle starting at edge 16; out1 stays 0.
- Bounce: btn0 pattern 1,0,1,1,0,1,1,1,1 then held. Required: exactly one out0 pulse, occurring 4 consecutive synchronised highs after the final 0.
- Short glitch: btn1 high for 3 cycles then low. Required: level1 and out1 never assert.
- Simultaneous: btn0 and btn1 rise on the same edge. Required: out0 and out1 pulse in the same cycle; release of both produces no pulses.
- Reset mid-press: btn0 held; rst=1 for 2 cycles two cycles after level0 rises. Required: all outputs 0 during reset; after rst=0, a single out0 pulse 7 cycles later.
- LONG_PRESS_EN: btn0 held 40 cycles. Required: one out0 pulse; one long0 pulse 20 cycles after level0 rises; no second long0.
